dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words in the backing array.
REQ-002 Parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 reset  input  1  meaning synchronous, active-high reset.
REQ-005 req_valid  input  1  meaning a load or store request is present.
REQ-006 req_ready  output  1  meaning the responder can accept a request this cycle.
REQ-007 req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 req_addr  input  32  meaning byte address; bits [1:0] are ignored.
REQ-009 req_wstrb  input  4  meaning byte-lane write enables, where bit i enables wdata[8i+7:8i].
REQ-010 req_wdata  input  32  meaning store data, lane-aligned.
REQ-011 resp_valid  output  1  meaning a single-cycle completion pulse (dcache_ok), with no backpressure.
REQ-012 resp_rdata  output  32  meaning the full aligned word for loads and 0 for stores; the requester performs byte extraction and sign extension.

Function
REQ-013 The responder SHALL implement three states: IDLE, WAIT and RESP.
REQ-014 req_ready SHALL be 1 in IDLE and 0 in WAIT and RESP.
REQ-015 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge; that edge is the accept edge.
REQ-016 Word index SHALL be req_addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so aliasing and wrap-around are permitted.
REQ-017 On a store accept edge, the enabled byte lanes SHALL be written; disabled lanes SHALL remain unchanged; wstrb=0000 SHALL write nothing but still produce a response.
REQ-018 On a load accept edge, the indexed word SHALL be captured into a response register, so later array changes do not alter the returned data.
REQ-019 On accept, a down-counter SHALL load the effective latency minus 1; the state SHALL go to RESP if that value is 0, otherwise to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle and the state SHALL move to RESP when the counter reaches 0.
REQ-021 In RESP, resp_valid SHALL be 1 for exactly one cycle; resp_rdata SHALL be valid in that cycle; the state SHALL return to IDLE on the next edge.
REQ-022 resp_valid SHALL therefore first be 1 in the cycle beginning exactly one effective latency after the accept edge.
REQ-023 resp_rdata SHALL hold its last value outside RESP.
REQ-024 Maximum throughput SHALL be one request per effective latency plus 1 cycles.
REQ-025 req_valid asserted while req_ready is 0 SHALL be ignored; the requester holds it until accepted.
REQ-026 A load issued after a store to the same word SHALL return the updated data.

Reset
REQ-027 On reset, the state SHALL be IDLE, req_ready SHALL be 1, resp_valid SHALL be 0, resp_rdata SHALL be 0 and the counter SHALL be 0.
REQ-028 Reset during WAIT or RESP SHALL abandon the request with no resp_valid pulse; a store already committed at its accept edge SHALL remain in the array.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 A request presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-031 When DCACHE_RAND_DELAY_EN is defined, a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001) SHALL advance every cycle, including during reset release.
REQ-032 With DCACHE_RAND_DELAY_EN defined, the effective latency SHALL be LATENCY + lfsr[1:0] sampled at the accept edge, giving a range of LATENCY..LATENCY+3.
REQ-033 Without DCACHE_RAND_DELAY_EN, the effective latency SHALL equal LATENCY, no LFSR logic SHALL exist, and timing SHALL be fully deterministic.

Verification
REQ-034 Store then load: store addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 1111, then load 0x10 -> load returns 0xDEADBEEF with resp_valid a single-cycle pulse LATENCY cycles after each accept.
REQ-035 Partial store: with word 0x10 = 0xDEADBEEF, store wdata 0x0000AA00, wstrb 0010 -> load 0x10 returns 0xDEADAAEF.
REQ-036 Aliasing: store 0x11223344 to 0x0000_1010 with DEPTH_LOG2=10 -> load 0x0000_0010 returns 0x11223344; load 0x10 with req_addr[1:0]=11 returns the same word.
REQ-037 Handshake: hold req_valid=1 continuously -> req_ready is 0 from the accept edge until the cycle after resp_valid, and exactly one request is accepted every LATENCY+1 cycles.
REQ-038 Reset mid-op: accept a store of 0xCAFEF00D, then pulse reset in WAIT -> no resp_valid pulse, req_ready is 1 the cycle after reset, and a later load returns 0xCAFEF00D.
REQ-039 Random latency: with DCACHE_RAND_DELAY_EN defined and LATENCY=1, over 100 loads every response latency lies in 1..4 and every returned value is correct.

Source files
------------

// File: rtl/dcache_responder.sv
// dcache_responder: single-outstanding data-memory responder with fixed or LFSR-jittered latency (optional DCACHE_RAND_DELAY_EN)
module dcache_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0] eff_lat;
  logic [DEPTH_LOG2-1:0] idx;
  logic accept;
  logic unused_addr;
  assign idx = req_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign accept = req_valid && state_q == IDLE && !reset;
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
`ifdef DCACHE_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;
  // x^4+x^3+1 Fibonacci LFSR supplying 0..3 cycles of extra latency
  always_comb lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  // LFSR register, reseeded on reset
  always_ff @(posedge clk) lfsr_q <= reset ? 4'b1001 : lfsr_d;
  assign eff_lat = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
  assign eff_lat = 5'(LATENCY);
`endif
  // next-state, latency countdown and response data capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    if (accept) begin
      cnt_d = eff_lat - 5'd1;
      state_d = eff_lat == 5'd1 ? RESP : WAIT;
      data_d = req_we ? 32'd0 : mem[idx];
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 5'd1;
      state_d = cnt_q == 5'd1 ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    rdata_d = (state_d == RESP && state_q != RESP) ? data_d : rdata_q;
  end
  // control and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      data_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
    end
  end
  // byte-lane store into the backing array at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && req_we)
      for (int i = 0; i < 4; i++)
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed scoreboard bench for dcache_responder
module tb_dcache_responder;
  localparam int LAT = 2;
  localparam int DL = 10;
`ifdef DCACHE_RAND_DELAY_EN
  localparam int LMAX = LAT + 3;
`else
  localparam int LMAX = LAT;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0] req_wstrb = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic resp_valid;
  logic [31:0] resp_rdata;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model [0:1023];
  logic [31:0] sb [$];

  dcache_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL+1:2]);
  endfunction

  task automatic model_apply(input logic we, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] wd, output logic [31:0] exp);
    logic [31:0] w;
    w = model[widx(a)];
    if (we) begin
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[widx(a)] = w;
      exp = 32'd0;
    end else exp = w;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd);
    int n;
    int lat;
    logic [31:0] exp;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wstrb = s; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept_timeout"}, 32'(n < 50), 32'd1);
    model_apply(we, a, s, wd, exp);
    sb.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; chk({tag, "_busy"}, 32'(req_ready), 32'd0); end
    while (!resp_valid && lat < 40);
    chk({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    chk({tag, "_lat_range"}, 32'(lat >= LAT && lat <= LMAX), 32'd1);
    if (sb.size() > 0) chk({tag, "_rdata"}, resp_rdata, sb.pop_front());
    @(negedge clk);
    chk({tag, "_pulse_single"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, "_rdata_hold"}, resp_rdata, exp);
  endtask

  initial begin
    int t, t_acc, last_acc, nresp, lat, pulses;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    xfer("st_full", 1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF);
    xfer("ld_full", 1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    xfer("st_part", 1'b1, 32'h0000_0010, 4'b0010, 32'h0000AA00);
    xfer("ld_part", 1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    chk("ld_part_const", model[4], 32'hDEADAAEF);
    xfer("st_alias", 1'b1, 32'h0000_1010, 4'b1111, 32'h11223344);
    xfer("ld_alias", 1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    xfer("ld_lowbits", 1'b0, 32'h0000_0013, 4'b0000, 32'h0);
    xfer("st_nostrb", 1'b1, 32'h0000_0010, 4'b0000, 32'hFFFFFFFF);
    xfer("ld_nostrb", 1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    chk("alias_const", model[4], 32'h11223344);
    // request presented only while reset is high is never accepted
    xfer("st_40", 1'b1, 32'h0000_0040, 4'b1111, 32'h12345678);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
    req_wstrb = 4'hF; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("rst2_ready", 32'(req_ready), 32'd1);
    chk("rst2_valid", 32'(resp_valid), 32'd0);
    chk("rst2_rdata", resp_rdata, 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (resp_valid) pulses++; end
    chk("rst2_no_pulse", 32'(pulses), 32'd0);
    xfer("ld_40", 1'b0, 32'h0000_0040, 4'b0000, 32'h0);
    // continuous req_valid: back-to-back loads spaced one latency plus one
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    t = 0; nresp = 0; t_acc = -1; last_acc = -1; lat = 0;
    while (nresp < 4 && t < 100) begin
      if (resp_valid) begin
        lat = t - t_acc;
        chk("hs_lat", 32'(lat >= LAT && lat <= LMAX), 32'd1);
        chk("hs_ready_resp", 32'(req_ready), 32'd0);
        if (sb.size() > 0) chk("hs_rdata", resp_rdata, sb.pop_front());
        nresp++;
        if (nresp == 4) req_valid = 1'b0;
      end else if (req_ready) begin
        if (last_acc >= 0) chk("hs_gap", 32'(t - last_acc), 32'(lat + 1));
        last_acc = t; t_acc = t;
        sb.push_back(model[widx(32'h10)]);
      end
      @(negedge clk);
      t++;
    end
    chk("hs_count", 32'(nresp), 32'd4);
    // reset while waiting: store kept, no response
    @(negedge clk);
    chk("mid_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wstrb = 4'hF; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_wait", 32'(req_ready), 32'd0);
    chk("mid_wait_valid", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    @(negedge clk);
    chk("mid_ready_after", 32'(req_ready), 32'd1);
    repeat (6) begin if (resp_valid) pulses++; @(negedge clk); end
    chk("mid_no_pulse", 32'(pulses), 32'd0);
    model[widx(32'h80)] = 32'hCAFEF00D;
    xfer("ld_mid", 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
    // random aliased loads over a prefilled region
    for (int i = 0; i < 16; i++)
      xfer("fill", 1'b1, 32'h200 + 32'(4 * i), 4'hF, $urandom());
    for (int i = 0; i < 100; i++) begin
      a = {$urandom_range(0, 255) << 12} + 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      xfer("rnd", 1'b0, a, 4'h0, 32'h0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
